// File: rtl/execute_memory_stage.sv
// Execute stage and EX/MEM pipeline register: forwarding, saturating ALU, Z/V/N flags.
// Forwarding muxes are built only when EXEC_FORWARD_EN is defined.
module execute_memory_stage #(
   parameter int DW = 16,
   parameter int RW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enable,
   input  logic          flush,
   input  logic          RegWrite,
   input  logic          MemtoReg,
   input  logic          MemRead,
   input  logic          MemWrite,
   input  logic          ALUSrc,
   input  logic [3:0]    alu_op,
   input  logic [DW-1:0] rs_data,
   input  logic [DW-1:0] rt_data,
   input  logic [DW-1:0] imm,
   input  logic [RW-1:0] rs_addr,
   input  logic [RW-1:0] rt_addr,
   input  logic [RW-1:0] rd_addr,
   input  logic          memwb_regwrite,
   input  logic [RW-1:0] memwb_rd,
   input  logic [DW-1:0] memwb_data,
   output logic          exmem_RegWrite,
   output logic          exmem_MemtoReg,
   output logic          exmem_MemRead,
   output logic          exmem_MemWrite,
   output logic [RW-1:0] exmem_rd,
   output logic [DW-1:0] exmem_alu_result,
   output logic [DW-1:0] exmem_store_data,
   output logic [2:0]    flags
);

   typedef enum logic [3:0] {
      OP_ADD = 4'b0000,
      OP_SUB = 4'b0001,
      OP_XOR = 4'b0010,
      OP_SLL = 4'b0100,
      OP_SRA = 4'b0101,
      OP_ROR = 4'b0110,
      OP_LW  = 4'b1000,
      OP_SW  = 4'b1001,
      OP_LLB = 4'b1010,
      OP_LHB = 4'b1011,
      OP_PCS = 4'b1110
   } alu_op_t;

   localparam logic [DW-1:0] SAT_POS = {1'b0, {(DW-1){1'b1}}};
   localparam logic [DW-1:0] SAT_NEG = {1'b1, {(DW-1){1'b0}}};

   alu_op_t       op;
   logic [DW-1:0] a_op, bf_op, b_op;
   logic [DW-1:0] sum, diff, result;
   logic [2*DW-1:0] ror_tmp;
   logic signed [DW-1:0] sra_tmp;
   logic [3:0]    shamt;
   logic          ovf;

   assign op = alu_op_t'(alu_op);

`ifdef EXEC_FORWARD_EN
   // Loads sitting in EX/MEM are excluded: their data is not available until MEM/WB.
   logic exmem_fwd_ok;
   assign exmem_fwd_ok = exmem_RegWrite && !exmem_MemRead && (exmem_rd != '0);

   always_comb begin
      a_op = rs_data;
      if (exmem_fwd_ok && (exmem_rd == rs_addr))
         a_op = exmem_alu_result;
      else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rs_addr))
         a_op = memwb_data;
   end

   always_comb begin
      bf_op = rt_data;
      if (exmem_fwd_ok && (exmem_rd == rt_addr))
         bf_op = exmem_alu_result;
      else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rt_addr))
         bf_op = memwb_data;
   end
`else
   logic unused_fwd;
   assign unused_fwd = ^{memwb_regwrite, memwb_rd, memwb_data, rs_addr, rt_addr};
   assign a_op  = rs_data;
   assign bf_op = rt_data;
`endif

   assign b_op    = ALUSrc ? imm : bf_op;
   assign shamt   = imm[3:0];
   assign sum     = a_op + b_op;
   assign diff    = a_op - b_op;
   assign ror_tmp = {a_op, a_op} >> shamt;
   assign sra_tmp = $signed(a_op) >>> shamt;

   always_comb begin
      result = '0;
      ovf    = 1'b0;
      case (op)
         OP_ADD: begin
            ovf    = (a_op[DW-1] == b_op[DW-1]) && (sum[DW-1] != a_op[DW-1]);
            result = ovf ? (a_op[DW-1] ? SAT_NEG : SAT_POS) : sum;
         end
         OP_SUB: begin
            ovf    = (a_op[DW-1] != b_op[DW-1]) && (diff[DW-1] != a_op[DW-1]);
            result = ovf ? (a_op[DW-1] ? SAT_NEG : SAT_POS) : diff;
         end
         OP_XOR:        result = a_op ^ b_op;
         OP_SLL:        result = a_op << shamt;
         OP_SRA:        result = sra_tmp;
         OP_ROR:        result = ror_tmp[DW-1:0];
         OP_LW, OP_SW:  result = a_op + imm;
         OP_LLB:        result = (bf_op & 16'hFF00) | {8'h00, imm[7:0]};
         OP_LHB:        result = (bf_op & 16'h00FF) | {imm[7:0], 8'h00};
         OP_PCS:        result = imm;
         default:       result = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         flags <= '0;
      end else if (enable && !flush) begin
         case (op)
            OP_ADD, OP_SUB:                 flags <= {(result == '0), ovf, result[DW-1]};
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: flags[2] <= (result == '0);
            default:                        flags <= flags;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst || flush) begin
         exmem_RegWrite   <= 1'b0;
         exmem_MemtoReg   <= 1'b0;
         exmem_MemRead    <= 1'b0;
         exmem_MemWrite   <= 1'b0;
         exmem_rd         <= '0;
         exmem_alu_result <= '0;
         exmem_store_data <= '0;
      end else if (enable) begin
         exmem_RegWrite   <= RegWrite;
         exmem_MemtoReg   <= MemtoReg;
         exmem_MemRead    <= MemRead;
         exmem_MemWrite   <= MemWrite;
         exmem_rd         <= rd_addr;
         exmem_alu_result <= result;
         exmem_store_data <= bf_op;
      end
   end

endmodule

// File: tb/tb_execute_memory_stage.sv
// Directed bench for execute_memory_stage; forwarding expectations follow EXEC_FORWARD_EN.
module tb_execute_memory_stage;

   logic        clk = 1'b0;
   logic        rst, enable, flush;
   logic        RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc;
   logic [3:0]  alu_op;
   logic [15:0] rs_data, rt_data, imm;
   logic [3:0]  rs_addr, rt_addr, rd_addr;
   logic        memwb_regwrite;
   logic [3:0]  memwb_rd;
   logic [15:0] memwb_data;
   logic        exmem_RegWrite, exmem_MemtoReg, exmem_MemRead, exmem_MemWrite;
   logic [3:0]  exmem_rd;
   logic [15:0] exmem_alu_result, exmem_store_data;
   logic [2:0]  flags;

   int tests = 0;
   int fails = 0;
`ifdef EXEC_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   execute_memory_stage #(.DW(16), .RW(4)) dut (
      .clk(clk), .rst(rst), .enable(enable), .flush(flush),
      .RegWrite(RegWrite), .MemtoReg(MemtoReg), .MemRead(MemRead),
      .MemWrite(MemWrite), .ALUSrc(ALUSrc), .alu_op(alu_op),
      .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
      .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
      .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
      .exmem_RegWrite(exmem_RegWrite), .exmem_MemtoReg(exmem_MemtoReg),
      .exmem_MemRead(exmem_MemRead), .exmem_MemWrite(exmem_MemWrite),
      .exmem_rd(exmem_rd), .exmem_alu_result(exmem_alu_result),
      .exmem_store_data(exmem_store_data), .flags(flags)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ctl = {RegWrite, MemtoReg, MemRead, MemWrite}; inputs applied, then one edge, sampled 1 after
   task automatic ex(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] im, input logic [3:0] ra, input logic [3:0] rb,
                     input logic [3:0] rd, input logic src, input logic [3:0] ctl);
      alu_op = op; rs_data = a; rt_data = b; imm = im;
      rs_addr = ra; rt_addr = rb; rd_addr = rd; ALUSrc = src;
      {RegWrite, MemtoReg, MemRead, MemWrite} = ctl;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] ctl_word();
      return {8'h00, exmem_RegWrite, exmem_MemtoReg, exmem_MemRead, exmem_MemWrite, exmem_rd};
   endfunction

   initial begin
      rst = 1'b0; enable = 1'b1; flush = 1'b0;
      memwb_regwrite = 1'b0; memwb_rd = '0; memwb_data = '0;
      ex(4'h0, 16'h1234, 16'h1111, 16'h0, 4'd14, 4'd15, 4'd1, 1'b0, 4'b1000);
      ex(4'h0, 16'h1234, 16'h1111, 16'h0, 4'd14, 4'd15, 4'd1, 1'b0, 4'b1000);
      chk("reset_result", exmem_alu_result, 16'h0000);
      chk("reset_ctl", ctl_word(), 16'h0000);
      chk("reset_flags", {13'h0, flags}, 16'h0000);
      rst = 1'b1;

      ex(4'h0, 16'h7FF0, 16'h0020, 16'h0, 4'd14, 4'd15, 4'd1, 1'b0, 4'b1000);
      chk("add_pos_sat", exmem_alu_result, 16'h7FFF);
      chk("add_pos_sat_flags", {13'h0, flags}, 16'h0002);
      chk("add_ctl", ctl_word(), 16'h0081);
      chk("add_store", exmem_store_data, 16'h0020);
      ex(4'h1, 16'h0005, 16'h0005, 16'h0, 4'd14, 4'd15, 4'd2, 1'b0, 4'b1000);
      chk("sub_zero", exmem_alu_result, 16'h0000);
      chk("sub_zero_flags", {13'h0, flags}, 16'h0004);
      ex(4'h1, 16'h8000, 16'h0001, 16'h0, 4'd14, 4'd15, 4'd2, 1'b0, 4'b1000);
      chk("sub_neg_sat", exmem_alu_result, 16'h8000);
      chk("sub_neg_sat_flags", {13'h0, flags}, 16'h0003);
      ex(4'h2, 16'h00FF, 16'h00FF, 16'h0, 4'd14, 4'd15, 4'd3, 1'b0, 4'b1000);
      chk("xor_zero", exmem_alu_result, 16'h0000);
      chk("xor_flags_z_only", {13'h0, flags}, 16'h0007);
      ex(4'h4, 16'h0001, 16'h0000, 16'h0004, 4'd14, 4'd15, 4'd3, 1'b1, 4'b1000);
      chk("sll", exmem_alu_result, 16'h0010);
      chk("sll_flags", {13'h0, flags}, 16'h0003);
      ex(4'h5, 16'h8000, 16'h0000, 16'h0003, 4'd14, 4'd15, 4'd3, 1'b1, 4'b1000);
      chk("sra", exmem_alu_result, 16'hF000);
      ex(4'h6, 16'h0001, 16'h0000, 16'h0001, 4'd14, 4'd15, 4'd3, 1'b1, 4'b1000);
      chk("ror", exmem_alu_result, 16'h8000);
      ex(4'h6, 16'h1234, 16'h0000, 16'h0000, 4'd14, 4'd15, 4'd3, 1'b1, 4'b1000);
      chk("ror_zero", exmem_alu_result, 16'h1234);
      ex(4'hB, 16'h0000, 16'h1234, 16'h00AB, 4'd14, 4'd15, 4'd4, 1'b1, 4'b1000);
      chk("lhb", exmem_alu_result, 16'hAB34);
      chk("lhb_flags_hold", {13'h0, flags}, 16'h0003);
      ex(4'hA, 16'h0000, 16'h1234, 16'h00AB, 4'd14, 4'd15, 4'd4, 1'b1, 4'b1000);
      chk("llb", exmem_alu_result, 16'h12AB);
      ex(4'hE, 16'h0000, 16'h0000, 16'h0042, 4'd14, 4'd15, 4'd4, 1'b1, 4'b1000);
      chk("pcs", exmem_alu_result, 16'h0042);
      chk("pcs_flags_hold", {13'h0, flags}, 16'h0003);
      ex(4'h3, 16'h5555, 16'h3333, 16'h0000, 4'd14, 4'd15, 4'd4, 1'b0, 4'b1000);
      chk("reserved_op", exmem_alu_result, 16'h0000);

      ex(4'h8, 16'h0100, 16'h0000, 16'h0004, 4'd14, 4'd15, 4'd5, 1'b1, 4'b1110);
      chk("lw_addr", exmem_alu_result, 16'h0104);
      chk("lw_ctl", ctl_word(), 16'h00E5);
      ex(4'h8, 16'h00AA, 16'h0000, 16'h0002, 4'd5, 4'd15, 4'd6, 1'b1, 4'b1110);
      chk("load_not_forwarded", exmem_alu_result, 16'h00AC);
      ex(4'h9, 16'hFFFF, 16'h5A5A, 16'h0002, 4'd14, 4'd15, 4'd0, 1'b1, 4'b0001);
      chk("sw_wrap", exmem_alu_result, 16'h0001);
      chk("sw_store", exmem_store_data, 16'h5A5A);
      chk("sw_flags_hold", {13'h0, flags}, 16'h0003);

      ex(4'h0, 16'h8000, 16'h0001, 16'h0, 4'd14, 4'd15, 4'd3, 1'b0, 4'b1000);
      chk("add_neg", exmem_alu_result, 16'h8001);
      chk("add_neg_flags", {13'h0, flags}, 16'h0001);
      enable = 1'b0;
      ex(4'h1, 16'h0001, 16'h0002, 16'h0, 4'd14, 4'd15, 4'd7, 1'b0, 4'b1000);
      chk("stall_result", exmem_alu_result, 16'h8001);
      chk("stall_ctl", ctl_word(), 16'h0083);
      chk("stall_flags", {13'h0, flags}, 16'h0001);
      flush = 1'b1;
      ex(4'h1, 16'h0001, 16'h0002, 16'h0, 4'd14, 4'd15, 4'd7, 1'b0, 4'b1000);
      chk("flush_stalled_result", exmem_alu_result, 16'h0000);
      chk("flush_stalled_ctl", ctl_word(), 16'h0000);
      chk("flush_stalled_flags", {13'h0, flags}, 16'h0001);
      enable = 1'b1;
      ex(4'h0, 16'h0000, 16'h0000, 16'h0, 4'd14, 4'd15, 4'd7, 1'b0, 4'b1000);
      chk("flush_store", exmem_store_data, 16'h0000);
      chk("flush_flags_hold", {13'h0, flags}, 16'h0001);
      flush = 1'b0;

      ex(4'h0, 16'h1111, 16'h0000, 16'h0, 4'd1, 4'd0, 4'd3, 1'b0, 4'b1000);
      chk("fwd_setup", exmem_alu_result, 16'h1111);
      memwb_regwrite = 1'b1; memwb_rd = 4'd3; memwb_data = 16'h2222;
      ex(4'h0, 16'h0BAD, 16'h0000, 16'h0, 4'd3, 4'd0, 4'd4, 1'b0, 4'b1000);
      chk("fwd_exmem_priority", exmem_alu_result, FWD ? 16'h1111 : 16'h0BAD);
      ex(4'h0, 16'h0000, 16'h0000, 16'h0, 4'd1, 4'd0, 4'd0, 1'b0, 4'b1000);
      ex(4'h0, 16'h0BAD, 16'h0000, 16'h0, 4'd3, 4'd0, 4'd4, 1'b0, 4'b1000);
      chk("fwd_memwb_rd0_exmem", exmem_alu_result, FWD ? 16'h2222 : 16'h0BAD);
      ex(4'h9, 16'h0010, 16'h0BAD, 16'h0004, 4'd1, 4'd3, 4'd0, 1'b1, 4'b0001);
      chk("fwd_store_rt", exmem_store_data, FWD ? 16'h2222 : 16'h0BAD);
      chk("sw_addr", exmem_alu_result, 16'h0014);
      memwb_regwrite = 1'b0;

      ex(4'h0, 16'h8000, 16'h8000, 16'h0, 4'd1, 4'd1, 4'd9, 1'b0, 4'b1000);
      chk("pre_reset_flags", {13'h0, flags}, 16'h0003);
      #2 rst = 1'b0;
      #1;
      chk("async_reset_result", exmem_alu_result, 16'h0000);
      chk("async_reset_ctl", ctl_word(), 16'h0000);
      chk("async_reset_flags", {13'h0, flags}, 16'h0000);
      @(negedge clk);
      rst = 1'b1;
      ex(4'h0, 16'hFFFF, 16'hFFFE, 16'h0, 4'd14, 4'd15, 4'd2, 1'b0, 4'b1000);
      chk("post_reset_add", exmem_alu_result, 16'hFFFD);
      chk("post_reset_flags", {13'h0, flags}, 16'h0001);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
